// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared register-file sizing and operand typedefs used by the
//               decode, register-file and writeback stages.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int RF_DATA_WIDTH    = 32;
    localparam int RF_NUM_REGISTERS = 32;
    localparam int RF_ADDR_WIDTH    = $clog2(RF_NUM_REGISTERS);

    typedef logic [RF_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [RF_DATA_WIDTH-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port
// Description : One combinational register-file read port with write-through
//               bypass so a same-cycle writeback is visible to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_read_port #(
    parameter int  DATA_WIDTH    = 32,
    parameter int  NUM_REGISTERS = 32,
    localparam int ADDR_WIDTH    = $clog2(NUM_REGISTERS)
) (
    input  logic                                rst,
    input  logic [ADDR_WIDTH-1:0]               rd_addr,
    input  logic [NUM_REGISTERS*DATA_WIDTH-1:0] regs_flat,
    input  logic                                byp_en,
    input  logic [ADDR_WIDTH-1:0]               byp_addr,
    input  logic [DATA_WIDTH-1:0]               byp_data,
    output logic [DATA_WIDTH-1:0]               data_out
);

    logic byp_hit;

    // byp_en already excludes x0, so a bypass hit never returns non-zero for r0
    assign byp_hit = byp_en && (rd_addr == byp_addr);

    always_comb begin
        data_out = '0;
        if (!rst) begin
            data_out = '0;
        end else if (byp_hit) begin
            data_out = byp_data;
        end else if (rd_addr == '0) begin
            data_out = '0;
        end else begin
            data_out = regs_flat[rd_addr*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : RISC-V integer register file, 2 combinational read ports,
//               1 synchronous write port, x0 hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import rf_pkg::*;
#(
    parameter int  DATA_WIDTH    = RF_DATA_WIDTH,
    parameter int  NUM_REGISTERS = RF_NUM_REGISTERS,
    localparam int ADDR_WIDTH    = $clog2(NUM_REGISTERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] reg_rd0,
    input  logic [ADDR_WIDTH-1:0] reg_rd1,
    input  logic [ADDR_WIDTH-1:0] reg_wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out0,
    output logic [DATA_WIDTH-1:0] data_out1
);

    logic [DATA_WIDTH-1:0]               regs_q [1:NUM_REGISTERS-1];
    logic [DATA_WIDTH-1:0]               regs_d [1:NUM_REGISTERS-1];
    logic [NUM_REGISTERS*DATA_WIDTH-1:0] regs_flat;
    logic                                wr_en;

    assign wr_en = rst && write && (reg_wr != '0);

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGISTERS; i++) begin
            if (wr_en && (reg_wr == ADDR_WIDTH'(i))) begin
                regs_d[i] = data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NUM_REGISTERS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGISTERS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Slot 0 of the flat view is tied to zero; x0 has no storage
    assign regs_flat[DATA_WIDTH-1:0] = '0;

    for (genvar g = 1; g < NUM_REGISTERS; g++) begin : g_flat
        assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    rf_read_port #(
        .DATA_WIDTH    (DATA_WIDTH),
        .NUM_REGISTERS (NUM_REGISTERS)
    ) u_rd0 (
        .rst       (rst),
        .rd_addr   (reg_rd0),
        .regs_flat (regs_flat),
        .byp_en    (wr_en),
        .byp_addr  (reg_wr),
        .byp_data  (data_in),
        .data_out  (data_out0)
    );

    rf_read_port #(
        .DATA_WIDTH    (DATA_WIDTH),
        .NUM_REGISTERS (NUM_REGISTERS)
    ) u_rd1 (
        .rst       (rst),
        .rd_addr   (reg_rd1),
        .regs_flat (regs_flat),
        .byp_en    (wr_en),
        .byp_addr  (reg_wr),
        .byp_data  (data_in),
        .data_out  (data_out1)
    );

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Directed self-checking bench for register_file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        write;
    logic [4:0]  reg_rd0;
    logic [4:0]  reg_rd1;
    logic [4:0]  reg_wr;
    logic [31:0] data_in;
    logic [31:0] data_out0;
    logic [31:0] data_out1;

    logic [31:0] model [0:31];
    int          errors;
    int          checks;

    register_file dut (
        .clk       (clk),
        .rst       (rst),
        .write     (write),
        .reg_rd0   (reg_rd0),
        .reg_rd1   (reg_rd1),
        .reg_wr    (reg_wr),
        .data_in   (data_in),
        .data_out0 (data_out0),
        .data_out1 (data_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        write   = 1'b1;
        reg_wr  = addr;
        data_in = data;
        @(posedge clk);
        #1;
        write = 1'b0;
        if (addr != 5'd0) model[addr] = data;
    endtask

    task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1);
        reg_rd0 = a0;
        reg_rd1 = a1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            set_reads(5'(a), 5'(31 - a));
            checks++;
            if (data_out0 !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd0 addr=%0d got=%h exp=%h", a, data_out0, 32'h0);
            end
            checks++;
            if (data_out1 !== 32'h0) begin
                errors++;
                $display("FAIL reset_rd1 addr=%0d got=%h exp=%h", 31 - a, data_out1, 32'h0);
            end
        end
        // write requested during reset must be neither stored nor bypassed
        write = 1'b1; reg_wr = 5'd3; data_in = 32'hCAFEF00D;
        set_reads(5'd3, 5'd3);
        checks++;
        if (data_out0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_no_bypass got=%h exp=%h", data_out0, 32'h0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        write = 1'b0;
        rst   = 1'b1;
        set_reads(5'd3, 5'd0);
        checks++;
        if (data_out0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_no_write got=%h exp=%h", data_out0, 32'h0);
        end
        clear_model();
    endtask

    task automatic test_basic();
        do_write(5'd1, 32'hDEADBEEF);
        do_write(5'd2, 32'h12345678);
        set_reads(5'd1, 5'd2);
        checks++;
        if (data_out0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_rd0 got=%h exp=%h", data_out0, 32'hDEADBEEF);
        end
        checks++;
        if (data_out1 !== 32'h12345678) begin
            errors++;
            $display("FAIL basic_rd1 got=%h exp=%h", data_out1, 32'h12345678);
        end
        set_reads(5'd2, 5'd2);
        checks++;
        if (data_out0 !== 32'h12345678 || data_out1 !== 32'h12345678) begin
            errors++;
            $display("FAIL same_addr got0=%h got1=%h exp=%h", data_out0, data_out1, 32'h12345678);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        write = 1'b1; reg_wr = 5'd0; data_in = 32'hFFFFFFFF;
        set_reads(5'd0, 5'd0);
        checks++;
        if (data_out0 !== 32'h0 || data_out1 !== 32'h0) begin
            errors++;
            $display("FAIL x0_bypass got0=%h got1=%h exp=%h", data_out0, data_out1, 32'h0);
        end
        @(posedge clk); #1;
        write = 1'b0;
        set_reads(5'd0, 5'd0);
        checks++;
        if (data_out0 !== 32'h0 || data_out1 !== 32'h0) begin
            errors++;
            $display("FAIL x0_read got0=%h got1=%h exp=%h", data_out0, data_out1, 32'h0);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        write = 1'b1; reg_wr = 5'd5; data_in = 32'hA5A5A5A5;
        set_reads(5'd5, 5'd5);
        checks++;
        if (data_out0 !== 32'hA5A5A5A5 || data_out1 !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_both got0=%h got1=%h exp=%h", data_out0, data_out1, 32'hA5A5A5A5);
        end
        @(posedge clk); #1;
        write = 1'b0;
        model[5] = 32'hA5A5A5A5;
        #1;
        checks++;
        if (data_out0 !== 32'hA5A5A5A5 || data_out1 !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_after got0=%h got1=%h exp=%h", data_out0, data_out1, 32'hA5A5A5A5);
        end
        // one port hits the bypass, the other keeps reading stored data
        @(negedge clk);
        write = 1'b1; reg_wr = 5'd6; data_in = 32'h0F0F1234;
        set_reads(5'd5, 5'd6);
        checks++;
        if (data_out0 !== 32'hA5A5A5A5 || data_out1 !== 32'h0F0F1234) begin
            errors++;
            $display("FAIL bypass_single got0=%h got1=%h exp0=%h exp1=%h",
                     data_out0, data_out1, 32'hA5A5A5A5, 32'h0F0F1234);
        end
        @(posedge clk); #1;
        write = 1'b0;
        model[6] = 32'h0F0F1234;
    endtask

    task automatic test_async_reset();
        for (int i = 1; i < 32; i++) do_write(5'(i), $urandom);
        set_reads(5'd7, 5'd31);
        checks++;
        if (data_out0 !== model[7] || data_out1 !== model[31]) begin
            errors++;
            $display("FAIL prefill got0=%h got1=%h exp0=%h exp1=%h",
                     data_out0, data_out1, model[7], model[31]);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        write = 1'b1; reg_wr = 5'd7; data_in = 32'h55AA55AA;
        #1;
        for (int a = 0; a < 32; a++) begin
            set_reads(5'(a), 5'((a + 1) % 32));
            checks++;
            if (data_out0 !== 32'h0 || data_out1 !== 32'h0) begin
                errors++;
                $display("FAIL async_rst addr=%0d got0=%h got1=%h exp=%h", a, data_out0, data_out1, 32'h0);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        write = 1'b0;
        rst   = 1'b1;
        clear_model();
        set_reads(5'd7, 5'd1);
        checks++;
        if (data_out0 !== 32'h0 || data_out1 !== 32'h0) begin
            errors++;
            $display("FAIL async_no_write got0=%h got1=%h exp=%h", data_out0, data_out1, 32'h0);
        end
    endtask

    task automatic test_sweep();
        for (int i = 1; i < 32; i++) do_write(5'(i), $urandom);
        for (int a = 0; a < 32; a++) begin
            set_reads(5'(a), 5'((a + 1) % 32));
            checks++;
            if (data_out0 !== model[a]) begin
                errors++;
                $display("FAIL sweep_rd0 addr=%0d got=%h exp=%h", a, data_out0, model[a]);
            end
            checks++;
            if (data_out1 !== model[(a + 1) % 32]) begin
                errors++;
                $display("FAIL sweep_rd1 addr=%0d got=%h exp=%h", (a + 1) % 32, data_out1, model[(a + 1) % 32]);
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b0;
        write   = 1'b0;
        reg_rd0 = 5'd0;
        reg_rd1 = 5'd0;
        reg_wr  = 5'd0;
        data_in = 32'h0;
        clear_model();

        test_reset();
        test_basic();
        test_x0();
        test_bypass();
        test_async_reset();
        test_sweep();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
